metronome_bar: RTL and testbench

Parametrised successor to the single-output metronome. Generates sub-beat ticks, beat pulses and bar-accent pulses from a loadable BPM value, beats-per-bar setting and subdivision factor. Tempo changes apply phase-continuously at the next tick boundary, never mid-interval. Sits between the BPM button/counter logic, the click/LED drivers and the display.

---
 rtl/metronome_bar_pkg.sv | 56 +++++
 rtl/metronome_bar_seq_divider.sv | 83 ++++++++
 rtl/metronome_bar.sv | 207 ++++++++++++++++++++
 tb/tb_metronome_bar.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/metronome_bar_pkg.sv
// metronome_pkg: shared types and elaboration-time helpers for metronome_bar
// and seq_divider.
//   state_t       - sequencer state (IDLE, RUN)
//   clog2         - ceiling log2, used to size ports and counters
//   calc_dividend - clocks per minute for a given clock frequency
//   clamp_range   - generic unsigned clamp into [lo, hi]
//   clamp_bpm     - tempo clamp
//   clamp_subdiv  - ticks-per-beat clamp (0 maps to 1)
package metronome_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 32'd0) ? value - 32'd1 : 32'd0;
    r = 0;
    while (v > 32'd0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Clocks per minute; 64-bit so a 50 MHz clock does not overflow.
  function automatic longint unsigned calc_dividend(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

  function automatic int unsigned clamp_range(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  function automatic int unsigned clamp_bpm(input int unsigned bpm,
                                            input int unsigned lo,
                                            input int unsigned hi);
    return clamp_range(bpm, lo, hi);
  endfunction

  function automatic int unsigned clamp_subdiv(input int unsigned subdiv,
                                               input int unsigned max);
    return clamp_range(subdiv, 32'd1, max);
  endfunction

endpackage

// File: rtl/metronome_bar_seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   i_clk, i_reset  - clock, asynchronous active-high reset (aborts a divide)
//   i_start         - accepted only while idle; samples dividend and divisor
//   i_dividend      - W-bit dividend
//   i_divisor       - W-bit divisor (zero yields an all-ones quotient)
//   o_busy          - high from the cycle after i_start for W cycles
//   o_done          - one-cycle pulse, the cycle o_busy falls
//   o_quotient      - valid while o_done is high and held until next start
module seq_divider
  import metronome_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quotient
);

  localparam int CW = clog2(W + 1);

  logic [W-1:0]  rem_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  div_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;

  logic [W:0]    shifted_s;
  logic [W-1:0]  diff_s;
  logic          fits_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so only the shifted-out
  // carry bit needs to join the compare; the W-bit difference is exact.
  always_comb begin
    shifted_s = {rem_r, quo_r[W-1]};
    fits_s    = shifted_s[W] | (shifted_s[W-1:0] >= div_r);
    diff_s    = shifted_s[W-1:0] - div_r;
  end

  // Divider state: quotient bits shift into quo_r as dividend bits shift out.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      div_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        rem_r <= fits_s ? diff_s : shifted_s[W-1:0];
        quo_r <= {quo_r[W-2:0], fits_s};
        if (cnt_r == CW'(W - 1)) begin
          cnt_r  <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else if (i_start) begin
        rem_r  <= '0;
        quo_r  <= i_dividend;
        div_r  <= i_divisor;
        cnt_r  <= '0;
        busy_r <= 1'b1;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_quotient = quo_r;

endmodule

// File: rtl/metronome_bar.sv
// metronome_bar: tempo sequencer producing sub-beat ticks, beats and bar
// accents from a loadable BPM, subdivision and beats-per-bar.
//   i_clk, i_reset   - clock, asynchronous active-high reset
//   i_run            - level, 1 = running
//   i_bpm, i_subdiv  - requested tempo and ticks per beat, sampled by i_bpm_load
//   i_bpm_load       - one-cycle strobe, ignored while o_busy
//   i_beats_per_bar  - sampled at start and at every accent
//   o_tick/o_beat/o_accent - one-cycle pulses, nested (accent => beat => tick)
//   o_beat_idx       - current beat within bar, 0-based
//   o_period         - tick period in effect, in clocks
//   o_busy           - new period being computed
module metronome_bar
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int          CNT_W       = 34,
  parameter int          BPM_W       = 9,
  parameter int          BPM_MIN     = 30,
  parameter int          BPM_MAX     = 300,
  parameter int          DEFAULT_BPM = 120,
  parameter int          MAX_BEATS   = 16,
  parameter int          SUBDIV_MAX  = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_run,
  input  logic [BPM_W-1:0]                  i_bpm,
  input  logic [2:0]                        i_subdiv,
  input  logic                              i_bpm_load,
  input  logic [clog2(MAX_BEATS + 1)-1:0]   i_beats_per_bar,
  output logic                              o_tick,
  output logic                              o_beat,
  output logic                              o_accent,
  output logic [clog2(MAX_BEATS + 1)-1:0]   o_beat_idx,
  output logic [CNT_W-1:0]                  o_period,
  output logic                              o_busy
);

  localparam int BEAT_W = clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(calc_dividend(64'(CLK_HZ)));
  localparam logic [CNT_W-1:0] DEFAULT_PERIOD =
    CNT_W'(calc_dividend(64'(CLK_HZ)) / 64'(DEFAULT_BPM));

  // The fastest legal tempo must still leave at least two clocks per tick.
  if (calc_dividend(64'(CLK_HZ)) / 64'(BPM_MAX * SUBDIV_MAX) < 64'd2) begin : g_period_check
    $error("metronome_bar: fastest tick period is below 2 clocks");
  end

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    period_r;
  logic [CNT_W-1:0]    pending_r;
  logic                pending_valid_r;
  logic [2:0]          load_sub_r;
  logic [2:0]          pending_sub_r;
  logic [2:0]          subdiv_r;
  logic [2:0]          sub_idx_r;
  logic [BEAT_W-1:0]   beat_idx_r;
  logic [BEAT_W-1:0]   bpb_r;
  logic                tick_r;
  logic                beat_r;
  logic                accent_r;

  logic [BPM_W-1:0]    bpm_c_s;
  logic [2:0]          sub_c_s;
  logic [BEAT_W-1:0]   bpb_c_s;
  logic [31:0]         prod_s;
  logic [CNT_W-1:0]    divisor_s;
  logic                start_s;
  logic                div_busy_s;
  logic                div_done_s;
  logic [CNT_W-1:0]    div_quo_s;
  logic                tick_due_s;
  logic [2:0]          sub_next_s;
  logic                beat_due_s;
  logic [BEAT_W-1:0]   beat_next_s;
  logic                bar_wrap_s;

  // Input clamping, divisor formation and tick/beat/bar boundary decode.
  always_comb begin
    bpm_c_s     = BPM_W'(clamp_bpm(32'(i_bpm), BPM_MIN, BPM_MAX));
    sub_c_s     = 3'(clamp_subdiv(32'(i_subdiv), SUBDIV_MAX));
    bpb_c_s     = BEAT_W'(clamp_range(32'(i_beats_per_bar), 32'd1, MAX_BEATS));
    prod_s      = 32'(bpm_c_s) * 32'(sub_c_s);
    divisor_s   = CNT_W'(prod_s);
    start_s     = i_bpm_load & ~div_busy_s;
    tick_due_s  = (state_r == RUN) && i_run && (cnt_r == period_r - CNT_W'(1));
    sub_next_s  = sub_idx_r + 3'd1;
    // A tempo switch restarts the subdivision, so the switch tick is a beat.
    beat_due_s  = pending_valid_r | (sub_next_s >= subdiv_r);
    beat_next_s = beat_idx_r + BEAT_W'(1);
    bar_wrap_s  = (beat_next_s >= bpb_r);
  end

  seq_divider #(.W(CNT_W)) u_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (start_s),
    .i_dividend (DIVIDEND),
    .i_divisor  (divisor_s),
    .o_busy     (div_busy_s),
    .o_done     (div_done_s),
    .o_quotient (div_quo_s)
  );

  // Sequencer: interval counter, sub/beat indices, pulses and period handover.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      period_r        <= DEFAULT_PERIOD;
      pending_r       <= '0;
      pending_valid_r <= 1'b0;
      pending_sub_r   <= 3'd1;
      subdiv_r        <= 3'd1;
      sub_idx_r       <= 3'd0;
      beat_idx_r      <= '0;
      bpb_r           <= BEAT_W'(1);
      tick_r          <= 1'b0;
      beat_r          <= 1'b0;
      accent_r        <= 1'b0;
    end else begin
      tick_r   <= 1'b0;
      beat_r   <= 1'b0;
      accent_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r      <= '0;
          sub_idx_r  <= 3'd0;
          beat_idx_r <= '0;
          // Nothing is mid-interval while stopped, so a new period applies now.
          if (pending_valid_r) begin
            period_r        <= pending_r;
            subdiv_r        <= pending_sub_r;
            pending_valid_r <= 1'b0;
          end
          if (i_run) begin
            state_r  <= RUN;
            tick_r   <= 1'b1;
            beat_r   <= 1'b1;
            accent_r <= 1'b1;
            bpb_r    <= bpb_c_s;
          end
        end
        RUN: begin
          if (!i_run) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            sub_idx_r  <= 3'd0;
            beat_idx_r <= '0;
          end else if (tick_due_s) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
            if (pending_valid_r) begin
              period_r        <= pending_r;
              subdiv_r        <= pending_sub_r;
              pending_valid_r <= 1'b0;
              sub_idx_r       <= 3'd0;
            end else if (sub_next_s >= subdiv_r) begin
              sub_idx_r <= 3'd0;
            end else begin
              sub_idx_r <= sub_next_s;
            end
            if (beat_due_s) begin
              beat_r <= 1'b1;
              if (bar_wrap_s) begin
                beat_idx_r <= '0;
                accent_r   <= 1'b1;
                bpb_r      <= bpb_c_s;
              end else begin
                beat_idx_r <= beat_next_s;
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // Placed last so a result landing on a switch tick stays pending.
      if (div_done_s) begin
        pending_r       <= div_quo_s;
        pending_sub_r   <= load_sub_r;
        pending_valid_r <= 1'b1;
      end
    end
  end

  // Subdivision of the load in flight; it travels with the result to pending.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      load_sub_r <= 3'd1;
    end else if (start_s) begin
      load_sub_r <= sub_c_s;
    end
  end

  assign o_tick     = tick_r;
  assign o_beat     = beat_r;
  assign o_accent   = accent_r;
  assign o_beat_idx = beat_idx_r;
  assign o_period   = period_r;
  assign o_busy     = div_busy_s;

endmodule

// File: tb/tb_metronome_bar.sv
// tb_metronome_bar: directed self-checking bench for metronome_bar with
// CLK_HZ=1000 (60000 clocks per minute, default period 500) and a 10-bit BPM
// port so an out-of-range tempo of 1000 can be driven.
module tb_metronome_bar;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_run = 1'b0;
  logic [9:0]  i_bpm = 10'd120;
  logic [2:0]  i_subdiv = 3'd1;
  logic        i_bpm_load = 1'b0;
  logic [4:0]  i_beats_per_bar = 5'd4;
  logic        o_tick;
  logic        o_beat;
  logic        o_accent;
  logic [4:0]  o_beat_idx;
  logic [33:0] o_period;
  logic        o_busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int prev_t = 0;
  int t = 0;
  int n = 0;
  int stop_pulses = 0;

  metronome_bar #(
    .CLK_HZ (1000),
    .BPM_W  (10)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_run           (i_run),
    .i_bpm           (i_bpm),
    .i_subdiv        (i_subdiv),
    .i_bpm_load      (i_bpm_load),
    .i_beats_per_bar (i_beats_per_bar),
    .o_tick          (o_tick),
    .o_beat          (o_beat),
    .o_accent        (o_accent),
    .o_beat_idx      (o_beat_idx),
    .o_period        (o_period),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until the next tick (bounded) and returns its cycle number.
  task automatic wait_tick(output int tt);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!o_tick && i < 2000);
    tt = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_period", o_period, 500);
    chk("rst_tick", o_tick, 0);
    chk("rst_beat", o_beat, 0);
    chk("rst_accent", o_accent, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_idx", o_beat_idx, 0);
    i_reset = 1'b0;
    step();
    step();
    chk("idle_tick", o_tick, 0);

    // Start: immediate downbeat, then 4/4 at period 500
    i_run = 1'b1;
    step();
    chk("start_tick", o_tick, 1);
    chk("start_beat", o_beat, 1);
    chk("start_accent", o_accent, 1);
    chk("start_idx", o_beat_idx, 0);
    prev_t = cyc;
    for (int k = 1; k <= 4; k++) begin
      wait_tick(t);
      chk("bar_gap", t - prev_t, 500);
      chk("bar_beat", o_beat, 1);
      chk("bar_accent", o_accent, (k == 4) ? 1 : 0);
      chk("bar_idx", o_beat_idx, k % 4);
      prev_t = t;
    end

    // Load 60 bpm x2 while running: 60000/120 = 500, beats every 2nd tick
    i_bpm = 10'd60;
    i_subdiv = 3'd2;
    i_bpm_load = 1'b1;
    step();
    i_bpm_load = 1'b0;
    chk("div_busy_rise", o_busy, 1);
    n = 1;
    while (o_busy && n < 100) begin
      step();
      if (o_busy) n++;
    end
    chk("div_busy_len", n, 34);
    chk("div_period_held", o_period, 500);
    for (int k = 0; k < 4; k++) begin
      wait_tick(t);
      chk("sub2_gap", t - prev_t, 500);
      chk("sub2_beat", o_beat, (k % 2 == 0) ? 1 : 0);
      chk("sub2_idx", o_beat_idx, 1 + k / 2);
      prev_t = t;
    end

    // Load 1000 bpm / subdiv 0 -> clamped 300 x1 -> period 200; second load ignored
    i_bpm = 10'd1000;
    i_subdiv = 3'd0;
    i_bpm_load = 1'b1;
    step();
    i_bpm_load = 1'b0;
    chk("clamp_busy", o_busy, 1);
    repeat (5) step();
    i_bpm = 10'd50;
    i_subdiv = 3'd1;
    i_bpm_load = 1'b1;
    step();
    i_bpm_load = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      step();
      n++;
    end
    chk("clamp_busy_fall", o_busy, 0);
    chk("clamp_period_held", o_period, 500);
    step();
    chk("second_load_ignored", o_busy, 0);
    wait_tick(t);
    chk("switch_gap", t - prev_t, 500);
    chk("switch_beat", o_beat, 1);
    chk("switch_idx", o_beat_idx, 3);
    chk("switch_accent", o_accent, 0);
    chk("switch_period", o_period, 200);
    prev_t = t;
    wait_tick(t);
    chk("fast_gap", t - prev_t, 200);
    chk("fast_beat", o_beat, 1);
    chk("fast_idx", o_beat_idx, 0);
    chk("fast_accent", o_accent, 1);
    chk("fast_period", o_period, 200);

    // Stop mid-interval for 10 cycles, then restart with an immediate accent
    repeat (50) step();
    i_run = 1'b0;
    step();
    chk("stop_tick", o_tick, 0);
    chk("stop_idx", o_beat_idx, 0);
    stop_pulses = 0;
    repeat (10) begin
      step();
      if (o_tick || o_beat || o_accent) stop_pulses++;
    end
    chk("stop_pulses", stop_pulses, 0);
    i_run = 1'b1;
    step();
    chk("restart_tick", o_tick, 1);
    chk("restart_beat", o_beat, 1);
    chk("restart_accent", o_accent, 1);
    chk("restart_idx", o_beat_idx, 0);

    // Reset mid-divide (100 bpm would give 600): nothing stale survives
    i_bpm = 10'd100;
    i_subdiv = 3'd1;
    i_bpm_load = 1'b1;
    step();
    i_bpm_load = 1'b0;
    chk("rst2_busy_before", o_busy, 1);
    repeat (10) step();
    i_reset = 1'b1;
    i_run = 1'b0;
    #1;
    chk("rst2_busy", o_busy, 0);
    chk("rst2_period", o_period, 500);
    chk("rst2_tick", o_tick, 0);
    step();
    step();
    i_reset = 1'b0;
    repeat (40) step();
    chk("rst2_busy_after", o_busy, 0);
    chk("rst2_period_after", o_period, 500);
    i_run = 1'b1;
    step();
    chk("rst2_start_tick", o_tick, 1);
    prev_t = cyc;
    wait_tick(t);
    chk("rst2_gap", t - prev_t, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
